pic_priority_resolver: RTL and testbench

- Clocked interrupt-request/in-service stage of the 8259A PIC, directly upstream of the control logic.
- Captures IR lines into the IRR, applies the mask, and resolves priority (fully nested, optional rotation).
- Drives INT and the 3-bit vector consumed as INT_VEC; maintains the ISR from the INTA acknowledge phases and OCW2 EOI commands.

---
 rtl/pic_priority_resolver.sv | 236 +++++++++++++++++++++++
 tb/tb_pic_priority_resolver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pic_priority_resolver.sv
// 8259A IRR/ISR stage: input sync, IRR capture, masking, priority resolution, INTA/EOI handling.
// Optional rotation (pri_low register, auto-rotate, OCW2 rotate/set-priority codes) under PIC_ROTATE_EN.
module pic_priority_resolver #(
    parameter int unsigned NUM_IR      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icw1_wr,
    input  logic [NUM_IR-1:0] ir,
    input  logic [NUM_IR-1:0] imr,
    input  logic              ltim,
    input  logic              aeoi,
    input  logic              ocw2_wr,
    input  logic [7:0]        ocw2,
    input  logic              first_ack,
    input  logic              second_ack,
    output logic              int_out,
    output logic [2:0]        int_vec,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr
);

    typedef enum logic [2:0] {
        OCW_ROT_CLR   = 3'b000,
        OCW_NSEOI     = 3'b001,
        OCW_NOP       = 3'b010,
        OCW_SEOI      = 3'b011,
        OCW_ROT_SET   = 3'b100,
        OCW_ROT_NSEOI = 3'b101,
        OCW_SETPRI    = 3'b110,
        OCW_ROT_SEOI  = 3'b111
    } ocw2_cmd_e;

    // Returns {found, index} of the highest-priority set bit; priority runs p+1, p+2, ... p.
    function automatic logic [3:0] f_highest(input logic [7:0] v, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = p + 3'd1 + 3'(7 - k);
            if (v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [2:0] f_rank(input logic [2:0] i, input logic [2:0] p);
        return i - p - 3'd1;
    endfunction

    function automatic logic [7:0] f_onehot(input logic [2:0] i);
        return 8'b1 << i;
    endfunction

    logic [NUM_IR-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IR-1:0] r_s_prev;
    logic [NUM_IR-1:0] r_irr;
    logic [NUM_IR-1:0] r_isr;
    logic              r_int_out;
    logic [2:0]        r_int_vec;
    logic              r_ack1_d;
    logic              r_ack2_d;
    logic              r_frozen;
    logic              r_spurious;

    logic [NUM_IR-1:0] w_s_ir;
    logic [NUM_IR-1:0] w_req;
    logic              w_cand_vld;
    logic [2:0]        w_cand;
    logic              w_cur_vld;
    logic [2:0]        w_cur;
    logic              w_ack1_edge;
    logic              w_ack2_edge;
    logic              w_ack2_fall;
    logic              w_grant;
    logic [NUM_IR-1:0] w_isr_set;
    logic [NUM_IR-1:0] w_isr_clr;
    logic [NUM_IR-1:0] w_isr_nxt;
    logic [NUM_IR-1:0] w_irr_nxt;
    logic              w_frozen_nxt;
    logic              w_spurious_nxt;
    logic [2:0]        w_pri_low;
    logic [2:0]        w_pri_nxt;
    logic              w_auto_rot;
    logic              w_auto_rot_nxt;
    logic              w_cand_n_vld;
    logic [2:0]        w_cand_n;
    logic              w_cur_n_vld;
    logic [2:0]        w_cur_n;
    logic              w_int_out_nxt;
    logic [2:0]        w_int_vec_nxt;
    ocw2_cmd_e         w_cmd;
    logic [2:0]        w_lvl;
    logic              w_unused;

    assign w_s_ir      = r_sync[SYNC_STAGES-1];
    assign w_req       = r_irr & ~imr;
    assign w_cmd       = ocw2_cmd_e'(ocw2[7:5]);
    assign w_lvl       = ocw2[2:0];
    assign w_unused    = ^ocw2[4:3];
    assign w_ack1_edge = first_ack & ~r_ack1_d;
    assign w_ack2_edge = second_ack & ~r_ack2_d;
    assign w_ack2_fall = ~second_ack & r_ack2_d;
    assign {w_cand_vld, w_cand} = f_highest(w_req, w_pri_low);
    assign {w_cur_vld, w_cur}   = f_highest(r_isr, w_pri_low);
    assign w_grant = w_ack1_edge & w_cand_vld;

`ifdef PIC_ROTATE_EN
    logic [2:0] r_pri_low;
    logic       r_auto_rot;

    assign w_pri_low  = r_pri_low;
    assign w_auto_rot = r_auto_rot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pri_low  <= 3'd7;
            r_auto_rot <= 1'b0;
        end else if (icw1_wr) begin
            r_pri_low  <= 3'd7;
            r_auto_rot <= 1'b0;
        end else begin
            r_pri_low  <= w_pri_nxt;
            r_auto_rot <= w_auto_rot_nxt;
        end
    end
`else
    assign w_pri_low  = 3'd7;
    assign w_auto_rot = 1'b0;
`endif

    always_comb begin
        w_isr_set      = w_grant ? f_onehot(w_cand) : '0;
        w_isr_clr      = '0;
        w_pri_nxt      = w_pri_low;
        w_auto_rot_nxt = w_auto_rot;

        // AEOI is evaluated first so that an OCW2 priority write in the same cycle overrides it.
        if (w_ack2_edge && aeoi && !r_spurious && r_isr[r_int_vec]) begin
            w_isr_clr[r_int_vec] = 1'b1;
            if (w_auto_rot) w_pri_nxt = r_int_vec;
        end

        if (ocw2_wr) begin
            case (w_cmd)
                OCW_NSEOI: if (w_cur_vld) w_isr_clr[w_cur] = 1'b1;
                OCW_SEOI:  w_isr_clr[w_lvl] = 1'b1;
                OCW_ROT_NSEOI: if (w_cur_vld) begin
                    w_isr_clr[w_cur] = 1'b1;
`ifdef PIC_ROTATE_EN
                    w_pri_nxt = w_cur;
`endif
                end
                OCW_ROT_SEOI: begin
                    w_isr_clr[w_lvl] = 1'b1;
`ifdef PIC_ROTATE_EN
                    w_pri_nxt = w_lvl;
`endif
                end
`ifdef PIC_ROTATE_EN
                OCW_SETPRI:  w_pri_nxt = w_lvl;
                OCW_ROT_SET: w_auto_rot_nxt = 1'b1;
                OCW_ROT_CLR: w_auto_rot_nxt = 1'b0;
`endif
                default: ;
            endcase
        end

        w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;

        if (ltim) w_irr_nxt = w_s_ir;
        else      w_irr_nxt = w_s_ir & (r_irr | ~r_s_prev) & ~w_isr_set;

        if (w_ack1_edge)      w_frozen_nxt = 1'b1;
        else if (w_ack2_fall) w_frozen_nxt = 1'b0;
        else                  w_frozen_nxt = r_frozen;

        w_spurious_nxt = w_ack1_edge ? ~w_cand_vld : r_spurious;

        // INT and the tracked vector look at next-cycle IRR/ISR/priority so they line up with the registers.
        {w_cand_n_vld, w_cand_n} = f_highest(w_irr_nxt & ~imr, w_pri_nxt);
        {w_cur_n_vld, w_cur_n}   = f_highest(w_isr_nxt, w_pri_nxt);

        w_int_out_nxt = w_cand_n_vld
                      & (~w_cur_n_vld | (f_rank(w_cand_n, w_pri_nxt) < f_rank(w_cur_n, w_pri_nxt)))
                      & ~(first_ack | second_ack | w_frozen_nxt);

        if (w_ack1_edge)                      w_int_vec_nxt = w_cand_vld ? w_cand : 3'd7;
        else if (!w_frozen_nxt && w_cand_n_vld) w_int_vec_nxt = w_cand_n;
        else                                  w_int_vec_nxt = r_int_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_s_prev   <= '0;
            r_irr      <= '0;
            r_isr      <= '0;
            r_int_out  <= 1'b0;
            r_int_vec  <= '0;
            r_ack1_d   <= 1'b0;
            r_ack2_d   <= 1'b0;
            r_frozen   <= 1'b0;
            r_spurious <= 1'b0;
        end else if (icw1_wr) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_s_prev   <= '0;
            r_irr      <= '0;
            r_isr      <= '0;
            r_int_out  <= 1'b0;
            r_int_vec  <= '0;
            r_ack1_d   <= 1'b0;
            r_ack2_d   <= 1'b0;
            r_frozen   <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_sync[0] <= ir;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_s_prev   <= w_s_ir;
            r_irr      <= w_irr_nxt;
            r_isr      <= w_isr_nxt;
            r_int_out  <= w_int_out_nxt;
            r_int_vec  <= w_int_vec_nxt;
            r_ack1_d   <= first_ack;
            r_ack2_d   <= second_ack;
            r_frozen   <= w_frozen_nxt;
            r_spurious <= w_spurious_nxt;
        end
    end

    assign int_out = r_int_out;
    assign int_vec = r_int_vec;
    assign irr     = r_irr;
    assign isr     = r_isr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver; rotation checks follow PIC_ROTATE_EN.
module tb_pic_priority_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       icw1_wr;
    logic [7:0] ir;
    logic [7:0] imr;
    logic       ltim;
    logic       aeoi;
    logic       ocw2_wr;
    logic [7:0] ocw2;
    logic       first_ack;
    logic       second_ack;
    logic       int_out;
    logic [2:0] int_vec;
    logic [7:0] irr;
    logic [7:0] isr;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pic_priority_resolver #(
        .NUM_IR      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .icw1_wr    (icw1_wr),
        .ir         (ir),
        .imr        (imr),
        .ltim       (ltim),
        .aeoi       (aeoi),
        .ocw2_wr    (ocw2_wr),
        .ocw2       (ocw2),
        .first_ack  (first_ack),
        .second_ack (second_ack),
        .int_out    (int_out),
        .int_vec    (int_vec),
        .irr        (irr),
        .isr        (isr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reinit();
        ir = '0;
        icw1_wr = 1'b1;
        tick(1);
        icw1_wr = 1'b0;
        tick(1);
    endtask

    task automatic inta();
        first_ack = 1'b1;  tick(1);
        first_ack = 1'b0;  tick(1);
        second_ack = 1'b1; tick(1);
        second_ack = 1'b0; tick(1);
    endtask

    task automatic ocw2_cmd(input logic [7:0] v);
        ocw2_wr = 1'b1;
        ocw2 = v;
        tick(1);
        ocw2_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; icw1_wr = 1'b0; ir = '0; imr = '0; ltim = 1'b0; aeoi = 1'b0;
        ocw2_wr = 1'b0; ocw2 = '0; first_ack = 1'b0; second_ack = 1'b0;
        #2;
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_int_out", int_out, 1'b0);
        chk("rst_int_vec", int_vec, 3'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Edge mode basic flow
        ir = 8'h0C;
        tick(2);
        chk("lat_int_early", int_out, 1'b0);
        tick(1);
        chk("lat_irr", irr, 8'h0C);
        chk("lat_int_out", int_out, 1'b1);
        chk("lat_int_vec", int_vec, 3'd2);
        first_ack = 1'b1; tick(1);
        chk("ack1_isr", isr, 8'h04);
        chk("ack1_irr", irr, 8'h08);
        chk("ack1_int_out", int_out, 1'b0);
        first_ack = 1'b0; tick(1);
        second_ack = 1'b1; tick(1);
        chk("ack2_noaeoi_isr", isr, 8'h04);
        chk("ack2_vec_frozen", int_vec, 3'd2);
        second_ack = 1'b0; tick(1);
        chk("nested_ir3_blocked", int_out, 1'b0);
        ocw2_cmd(8'h20);
        chk("nseoi_isr", isr, 8'h00);
        chk("nseoi_int_out", int_out, 1'b1);
        chk("nseoi_int_vec", int_vec, 3'd3);

        // Fully nested
        reinit();
        ir = 8'h08; tick(3);
        inta();
        chk("fn_isr", isr, 8'h08);
        ir = 8'h28; tick(3);
        chk("fn_irr5", irr, 8'h20);
        chk("fn_ir5_blocked", int_out, 1'b0);
        ir = 8'h2A; tick(3);
        chk("fn_ir1_int", int_out, 1'b1);
        chk("fn_ir1_vec", int_vec, 3'd1);

        // AEOI
        reinit();
        aeoi = 1'b1;
        ir = 8'h40; tick(3);
        chk("aeoi_int", int_out, 1'b1);
        chk("aeoi_vec", int_vec, 3'd6);
        first_ack = 1'b1; tick(1);
        chk("aeoi_ack1_isr", isr, 8'h40);
        first_ack = 1'b0; ir = 8'h00; tick(1);
        second_ack = 1'b1; tick(1);
        chk("aeoi_ack2_isr", isr, 8'h00);
        chk("aeoi_ack2_vec", int_vec, 3'd6);
        tick(1);
        chk("aeoi_vec_held", int_vec, 3'd6);
        second_ack = 1'b0; tick(1);
        chk("aeoi_done_int", int_out, 1'b0);
        aeoi = 1'b0;

        // Spurious
        reinit();
        ir = 8'h10; tick(3);
        chk("sp_vec4", int_vec, 3'd4);
        ir = 8'h00; tick(3);
        chk("sp_irr_drop", irr, 8'h00);
        chk("sp_int_drop", int_out, 1'b0);
        first_ack = 1'b1; tick(1);
        chk("sp_vec7", int_vec, 3'd7);
        chk("sp_isr", isr, 8'h00);
        first_ack = 1'b0; tick(1);
        second_ack = 1'b1; tick(1);
        second_ack = 1'b0; tick(1);

        // Rotation / set priority
        reinit();
        ocw2_cmd(8'hC4);
        ir = 8'h21; tick(3);
`ifdef PIC_ROTATE_EN
        chk("rot_vec5", int_vec, 3'd5);
        chk("rot_int", int_out, 1'b1);
        inta();
        chk("rot_isr", isr, 8'h20);
        ocw2_cmd(8'hE5);
        chk("rot_seoi_isr", isr, 8'h00);
        ir = 8'h61; tick(3);
        chk("rot_ir6_top", int_vec, 3'd6);
        chk("rot_irr", irr, 8'h41);
`else
        chk("norot_vec0", int_vec, 3'd0);
        chk("norot_int", int_out, 1'b1);
        inta();
        chk("norot_isr", isr, 8'h01);
        ocw2_cmd(8'hE0);
        chk("norot_seoi_isr", isr, 8'h00);
        chk("norot_int2", int_out, 1'b1);
        chk("norot_vec5", int_vec, 3'd5);
`endif

        // Level mode, masking, reset mid-INTA
        reinit();
        ltim = 1'b1;
        imr = 8'h04;
        ir = 8'h04; tick(3);
        chk("lvl_irr", irr, 8'h04);
        chk("lvl_masked", int_out, 1'b0);
        imr = 8'h00; tick(1);
        chk("lvl_unmask_int", int_out, 1'b1);
        chk("lvl_unmask_vec", int_vec, 3'd2);
        first_ack = 1'b1; tick(1);
        chk("lvl_ack1_isr", isr, 8'h04);
        rst_n = 1'b0;
        #1;
        chk("midrst_irr", irr, 8'h00);
        chk("midrst_isr", isr, 8'h00);
        chk("midrst_int", int_out, 1'b0);
        #2;
        first_ack = 1'b0;
        rst_n = 1'b1;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
